// File: rtl/buffered_matrixn_colorspace_converter.sv
// RGB->gray converter with circular line buffers producing a sliding NxN gray window.
// Optional build macro MATRIX_EXCLUDE_CENTER_EN drops the window center from O_PIXEL_MATRIX.

module buffered_matrixn_colorspace_converter_lbuf #(
  parameter int P_DEPTH     = 640,
  parameter int P_ADDR_BITS = 10,
  parameter int P_WIDTH     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [P_ADDR_BITS-1:0] i_addr,
  input  logic [P_WIDTH-1:0]     i_wdata,
  output logic [P_WIDTH-1:0]     o_rdata
);
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];

  // Asynchronous read gives read-before-write on the shared column address.
  assign o_rdata = mem_q[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_addr] <= i_wdata;
  end
endmodule

module buffered_matrixn_colorspace_converter #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_PIXEL_DEPTH       = 24,
  parameter int P_MATRIX_SIZE       = 3,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET_N,
  input  logic                           I_FRAME_START,
  input  logic                           I_PIXEL_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
`ifdef MATRIX_EXCLUDE_CENTER_EN
  output logic [(P_MATRIX_SIZE*P_MATRIX_SIZE-1)*(P_PIXEL_DEPTH/3)-1:0] O_PIXEL_MATRIX,
`else
  output logic [P_MATRIX_SIZE*P_MATRIX_SIZE*(P_PIXEL_DEPTH/3)-1:0]     O_PIXEL_MATRIX,
`endif
  output logic                           O_PIXEL_MATRIX_VALID,
  output logic                           O_FRAME_DONE
);
  localparam int N  = P_MATRIX_SIZE;
  localparam int D  = P_PIXEL_DEPTH / 3;
  localparam int NB = N - 1;
  localparam int PB = (NB > 1) ? $clog2(NB) : 1;
  localparam int CB = P_FRAME_COLUMN_BITS;
  localparam int RB = P_FRAME_ROW_BITS;
`ifdef MATRIX_EXCLUDE_CENTER_EN
  localparam int CELLS = N*N - 1;
`else
  localparam int CELLS = N*N;
`endif
  localparam int CENTER = (N*N) / 2;
  localparam logic [CB-1:0] LAST_COL = CB'(P_FRAME_COLUMNS - 1);
  localparam logic [RB-1:0] LAST_ROW = RB'(P_FRAME_ROWS - 1);
  localparam logic [CB-1:0] EDGE_COL = CB'(N - 1);
  localparam logic [RB-1:0] EDGE_ROW = RB'(N - 1);

  typedef enum logic [1:0] {S_WAIT_SOF, S_ACTIVE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CB-1:0] col_q, col_d;
  logic [RB-1:0] row_q, row_d;

  logic          vld1_q, vld1_d;
  logic          last1_q, last1_d;
  logic [D-1:0]  gray1_q, gray1_d;
  logic [CB-1:0] col1_q, col1_d;
  logic [RB-1:0] row1_q, row1_d;

  logic [N-1:0][N-1:0][D-1:0] win_q, win_d;
  logic [PB-1:0]  ptr_q, ptr_d;
  logic [NB-1:0]  lb_we;
  logic [D-1:0]   lb_rdata [NB];

  logic [CELLS*D-1:0] mat_q, mat_d;
  logic [CB-1:0]      ocol_q, ocol_d;
  logic [RB-1:0]      orow_q, orow_d;
  logic               mvalid_q, mvalid_d;
  logic               last2_q, last2_d;
  logic               done_q, done_d;
  logic               wvalid;

  logic         sof;
  logic [D+1:0] gray_sum;

  assign sof      = I_FRAME_START & I_PIXEL_VALID;
  assign gray_sum = {2'b00, I_PIXEL[3*D-1 -: D]} + {1'b0, I_PIXEL[2*D-1 -: D], 1'b0}
                  + {2'b00, I_PIXEL[D-1:0]};

  // Frame tracking: col_q/row_q hold the coordinate the next accepted pixel will get.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    vld1_d  = 1'b0;
    last1_d = 1'b0;
    col1_d  = col1_q;
    row1_d  = row1_q;
    gray1_d = gray1_q;
    if (sof) begin
      state_d = S_ACTIVE;
      col_d   = CB'(1);
      row_d   = '0;
      vld1_d  = 1'b1;
      col1_d  = '0;
      row1_d  = '0;
      gray1_d = D'(gray_sum >> 2);
    end else if (state_q == S_ACTIVE && I_PIXEL_VALID) begin
      vld1_d  = 1'b1;
      col1_d  = col_q;
      row1_d  = row_q;
      gray1_d = D'(gray_sum >> 2);
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
          row_d   = '0;
          last1_d = 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_WAIT_SOF;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lbuf
    buffered_matrixn_colorspace_converter_lbuf #(
      .P_DEPTH    (P_FRAME_COLUMNS),
      .P_ADDR_BITS(CB),
      .P_WIDTH    (D)
    ) u_lbuf (
      .i_clk  (I_CLK),
      .i_we   (lb_we[g]),
      .i_addr (col1_q),
      .i_wdata(gray1_q),
      .o_rdata(lb_rdata[g])
    );
  end

  // Window shift and output capture; buffer ptr_q holds the oldest row.
  always_comb begin
    int s;
    win_d    = win_q;
    ptr_d    = ptr_q;
    lb_we    = '0;
    mat_d    = mat_q;
    ocol_d   = ocol_q;
    orow_d   = orow_q;
    mvalid_d = 1'b0;
    last2_d  = 1'b0;
    done_d   = last2_q;
    s        = 0;
    wvalid   = vld1_q && (col1_q >= EDGE_COL) && (row1_q >= EDGE_ROW);
    if (vld1_q) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N-1; j++)
          win_d[i][j] = win_q[i][j+1];
      for (int i = 0; i < NB; i++) begin
        s = int'(ptr_q) + i;
        if (s >= NB) s = s - NB;
        for (int b = 0; b < NB; b++)
          if (b == s) win_d[i][N-1] = lb_rdata[b];
      end
      win_d[N-1][N-1] = gray1_q;
      for (int b = 0; b < NB; b++)
        lb_we[b] = (ptr_q == PB'(b));
      if (col1_q == LAST_COL)
        ptr_d = (ptr_q == PB'(NB-1)) ? '0 : ptr_q + 1'b1;
      // A restart right after the last pixel cancels the pending done pulse.
      last2_d = last1_q & ~sof;
    end
    if (wvalid) begin
      mvalid_d = 1'b1;
      ocol_d   = col1_q - EDGE_COL;
      orow_d   = row1_q - EDGE_ROW;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
`ifdef MATRIX_EXCLUDE_CENTER_EN
          if (i*N+j < CENTER)
            mat_d[(CELLS-1-(i*N+j))*D +: D] = win_d[i][j];
          else if (i*N+j > CENTER)
            mat_d[(CELLS-(i*N+j))*D +: D] = win_d[i][j];
`else
          mat_d[(CELLS-1-(i*N+j))*D +: D] = win_d[i][j];
`endif
        end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      state_q  <= S_WAIT_SOF;
      col_q    <= '0;
      row_q    <= '0;
      vld1_q   <= 1'b0;
      last1_q  <= 1'b0;
      ptr_q    <= '0;
      mat_q    <= '0;
      ocol_q   <= '0;
      orow_q   <= '0;
      mvalid_q <= 1'b0;
      last2_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      vld1_q   <= vld1_d;
      last1_q  <= last1_d;
      ptr_q    <= ptr_d;
      mat_q    <= mat_d;
      ocol_q   <= ocol_d;
      orow_q   <= orow_d;
      mvalid_q <= mvalid_d;
      last2_q  <= last2_d;
      done_q   <= done_d;
    end
  end

  // Datapath registers: contents are only consumed behind vld1_q.
  always_ff @(posedge I_CLK) begin
    gray1_q <= gray1_d;
    col1_q  <= col1_d;
    row1_q  <= row1_d;
    win_q   <= win_d;
  end

  assign O_PIXEL_COLUMN       = ocol_q;
  assign O_PIXEL_ROW          = orow_q;
  assign O_PIXEL_MATRIX       = mat_q;
  assign O_PIXEL_MATRIX_VALID = mvalid_q;
  assign O_FRAME_DONE         = done_q;
endmodule

// File: tb/tb_buffered_matrixn_colorspace_converter.sv
// Directed bench for buffered_matrixn_colorspace_converter: 8x6 frame, N=3, 24-bit RGB.
module tb_buffered_matrixn_colorspace_converter;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int N    = 3;
  localparam int D    = 8;
`ifdef MATRIX_EXCLUDE_CENTER_EN
  localparam int CELLS = N*N - 1;
  localparam logic [CELLS*D-1:0] FIRST_WIN = 64'h00_01_02_08_0A_10_11_12;
`else
  localparam int CELLS = N*N;
  localparam logic [CELLS*D-1:0] FIRST_WIN = 72'h00_01_02_08_09_0A_10_11_12;
`endif
  localparam int W = CELLS*D;

  logic         gclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sof = 1'b0;
  logic         vld = 1'b0;
  logic [23:0]  pix = '0;
  logic [2:0]   ocol;
  logic [2:0]   orow;
  logic [W-1:0] omat;
  logic         omv;
  logic         odone;

  buffered_matrixn_colorspace_converter #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(N)
  ) dut (
    .I_CLK(gclk), .I_RESET_N(rst_n), .I_FRAME_START(sof), .I_PIXEL_VALID(vld), .I_PIXEL(pix),
    .O_PIXEL_COLUMN(ocol), .O_PIXEL_ROW(orow), .O_PIXEL_MATRIX(omat),
    .O_PIXEL_MATRIX_VALID(omv), .O_FRAME_DONE(odone)
  );

  always #5 gclk = ~gclk;

  int nvec = 0, nmis = 0, npulse = 0, ndone = 0;
  int mst = 0, mc = 0, mr = 0;
  logic [7:0] gm [ROWS][COLS];
  bit p1_v = 0, p1_last = 0, p2_last = 0;
  int p1_c = 0, p1_r = 0, e_c = 0, e_r = 0, first_c = -1, first_r = -1;
  logic [W-1:0] p1_m = '0, e_m = '0, first_m = '0;
  logic [23:0] rgb_tab [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h010102};
  logic [7:0]  gray_tab [4] = '{8'hFF, 8'h3F, 8'h7F, 8'h01};

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] win(int c0, int r0);
    logic [W-1:0] m = '0;
    int k = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
`ifdef MATRIX_EXCLUDE_CENTER_EN
        if (i == N/2 && j == N/2) continue;
`endif
        m[(CELLS-1-k)*D +: D] = gm[r0+i][c0+j];
        k++;
      end
    return m;
  endfunction

  // One clock: drive, model the accepted pixel, sample at negedge, check.
  task automatic step(bit s, bit v, logic [23:0] rgb, logic [7:0] g);
    bit acc = 0, ev_v = 0, ev_last = 0;
    int c = 0, r = 0;
    sof = s; vld = v; pix = rgb;
    @(posedge gclk);
    if (s && v) begin
      acc = 1; mst = 1; mc = 1; mr = 0;
    end else if (v && mst == 1) begin
      acc = 1; c = mc; r = mr;
      if (mc == COLS-1) begin
        mc = 0; mr++;
        if (r == ROWS-1) begin mst = 2; ev_last = 1; end
      end else mc++;
    end else if (mst == 2) mst = 0;
    if (acc) begin
      gm[r][c] = g;
      ev_v = (c >= N-1 && r >= N-1);
    end
    if (s && v) p1_last = 0;
    @(negedge gclk);
    chk("valid", omv, p1_v);
    chk("done", odone, p2_last);
    if (p1_v) begin e_c = p1_c; e_r = p1_r; e_m = p1_m; end
    chk("col", ocol, e_c);
    chk("row", orow, e_r);
    chk("matrix", omat, e_m);
    if (omv && first_c < 0) begin first_c = ocol; first_r = orow; first_m = omat; end
    if (omv) npulse++;
    if (odone) ndone++;
    p2_last = p1_last;
    p1_v = ev_v;
    p1_last = ev_last;
    if (ev_v) begin
      p1_c = c-(N-1); p1_r = r-(N-1); p1_m = win(c-(N-1), r-(N-1));
    end
    sof = 0; vld = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; vld = 1; pix = 24'h123456;
    @(posedge gclk);
    @(negedge gclk);
    chk("rst_valid", omv, 0);
    chk("rst_done", odone, 0);
    chk("rst_col", ocol, 0);
    chk("rst_row", orow, 0);
    chk("rst_matrix", omat, 0);
    rst_n = 1; vld = 0;
    mst = 0; mc = 0; mr = 0;
    p1_v = 0; p1_last = 0; p2_last = 0;
    e_c = 0; e_r = 0; e_m = '0;
  endtask

  // Frame with gray = col + 8*row; stops before (stop_c, stop_r) if inside the frame.
  task automatic run_frame(int gap_max, bit rgb_mix, int stop_c, int stop_r);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        logic [7:0]  v;
        logic [23:0] rgb;
        if (r == stop_r && c == stop_c) return;
        v = 8'(c + 8*r);
        rgb = {v, v, v};
        if (rgb_mix && r == 2 && c < 4) begin rgb = rgb_tab[c]; v = gray_tab[c]; end
        for (int k = int'($urandom_range(gap_max, 0)); k > 0; k--) step(0, 0, 24'hABCDEF, 8'h00);
        step(r == 0 && c == 0, 1, rgb, v);
      end
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 24'h0, 8'h00);
  endtask

  initial begin
    do_reset();
    repeat (4) step(0, 1, 24'h101010, 8'h10);

    npulse = 0; ndone = 0;
    run_frame(0, 0, -1, -1); flush();
    chk("f1_pulses", npulse, 24);
    chk("f1_done", ndone, 1);
    chk("first_col", first_c, 0);
    chk("first_row", first_r, 0);
    chk("first_win", first_m, FIRST_WIN);

    npulse = 0; ndone = 0;
    run_frame(2, 0, -1, -1); flush();
    chk("gap_pulses", npulse, 24);
    chk("gap_done", ndone, 1);

    npulse = 0; ndone = 0;
    run_frame(0, 0, 4, 3);
    run_frame(0, 0, -1, -1); flush();
    chk("abort_pulses", npulse, 32);
    chk("abort_done", ndone, 1);

    npulse = 0; ndone = 0;
    run_frame(0, 1, -1, -1); flush();
    chk("rgb_pulses", npulse, 24);

    run_frame(0, 0, 3, 3);
    do_reset();
    npulse = 0; ndone = 0;
    repeat (10) step(0, 1, 24'h202020, 8'h20);
    chk("nosof_pulses", npulse, 0);
    run_frame(0, 0, -1, -1); flush();
    chk("post_rst_pulses", npulse, 24);
    chk("post_rst_done", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
